motor_pwm_driver: RTL and testbench

MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

---
 rtl/motor_pkg.sv | 28 ++
 rtl/pwm_channel.sv | 144 ++++++++++++++
 rtl/motor_pwm_driver.sv | 85 ++++++++
 tb/tb_motor_pwm_driver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor-control slice: the PID controller, the
// RPM reader and the PWM driver all import this package so that command
// width, channel count and the channel-select width derivation stay
// consistent across blocks.
//   MOTOR_DATA_WIDTH : width of the signed PID command word
//   MOTOR_NUM_CHN    : number of motor channels
//   chn_width()      : channel-select width, max(1, clog2(n))
//   chn_state_e      : per-channel output state (RUN / DEAD)
// ---------------------------------------------------------------------------
package motor_pkg;

    localparam int MOTOR_DATA_WIDTH = 16;
    localparam int MOTOR_NUM_CHN    = 4;

    // A single channel still needs one select bit so the port never collapses
    // to zero width.
    function automatic int chn_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } chn_state_e;

endpackage

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One motor channel of the PWM driver: shadow command register, active duty
// and direction, RUN/DEAD reversal FSM, PWM comparator and command watchdog.
//   clk, rst  : clock, synchronous active-high reset
//   cnt_i     : shared period counter value
//   load_i    : last cycle of the period (shadow -> active transfer)
//   start_i   : first cycle of the period (watchdog count event)
//   wr_i      : command write strobe for this channel
//   data_i    : signed command effort
//   pwm_o     : registered PWM output
//   dir_o     : direction, 1 = reverse
//   fault_o   : command timeout flag
// ---------------------------------------------------------------------------
module pwm_channel
    import motor_pkg::*;
#(
    parameter int DATA_WIDTH      = MOTOR_DATA_WIDTH,
    parameter int PWM_PERIOD      = 1000,
    parameter int TIMEOUT_PERIODS = 100,
    localparam int CNT_W          = $clog2(PWM_PERIOD)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT_W-1:0]             cnt_i,
    input  logic                         load_i,
    input  logic                         start_i,
    input  logic                         wr_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic                         pwm_o,
    output logic                         dir_o,
    output logic                         fault_o
);

    localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
    localparam int WD_W   = $clog2(TIMEOUT_PERIODS + 1);

    logic signed [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DUTY_W-1:0]            active_q, active_d;
    chn_state_e                   state_q, state_d;
    logic                         dir_q, dir_d;
    logic                         fault_q, fault_d;
    logic [WD_W-1:0]              wd_q, wd_d;
    logic                         pwm_q, pwm_d;

    logic signed [DATA_WIDTH-1:0] cmd;
    logic [DUTY_W-1:0]            cmd_duty;
    logic                         cmd_neg;
    logic                         timeout;

    // |v| clamped to the period. The extra bit keeps the most-negative
    // command from wrapping back to itself on negation.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH:0] ext;
        logic [DATA_WIDTH:0]        mag;
        ext = {v[DATA_WIDTH-1], v};
        mag = ext[DATA_WIDTH] ? $unsigned(-ext) : $unsigned(ext);
        if (64'(mag) > 64'(PWM_PERIOD)) begin
            return DUTY_W'(PWM_PERIOD);
        end
        return DUTY_W'(mag);
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        state_d  = state_q;
        dir_d    = dir_q;
        fault_d  = fault_q;
        wd_d     = wd_q;

        // A write landing in the load cycle is forwarded into the load.
        cmd      = wr_i ? data_i : shadow_q;
        cmd_duty = sat_duty(cmd);
        cmd_neg  = cmd[DATA_WIDTH-1];

        // A write in the same cycle as the expiry wins and re-arms the watchdog.
        timeout  = start_i && !wr_i && (wd_q == WD_W'(TIMEOUT_PERIODS - 1));

        // Output is blanked for the whole DEAD period and forced low as soon
        // as the watchdog fires.
        pwm_d    = (state_q == ST_RUN) && !timeout && (DUTY_W'(cnt_i) < active_q);

        if (load_i) begin
            active_d = cmd_duty;
            case (state_q)
                ST_RUN: begin
                    // Zero commands never reverse; direction is held until
                    // the dead period has elapsed.
                    if ((cmd_duty != '0) && (cmd_neg != dir_q)) begin
                        state_d = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    state_d = ST_RUN;
                    if (cmd_duty != '0) begin
                        dir_d = cmd_neg;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (wr_i) begin
            shadow_d = data_i;
            fault_d  = 1'b0;
            wd_d     = '0;
        end else if (timeout) begin
            shadow_d = '0;
            active_d = '0;
            state_d  = ST_RUN;
            fault_d  = 1'b1;
            wd_d     = WD_W'(TIMEOUT_PERIODS);
        end else if (start_i && (wd_q != WD_W'(TIMEOUT_PERIODS))) begin
            // Saturates at the limit so an expired channel fires only once.
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            state_q  <= ST_RUN;
            dir_q    <= 1'b0;
            fault_q  <= 1'b0;
            wd_q     <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            state_q  <= state_d;
            dir_q    <= dir_d;
            fault_q  <= fault_d;
            wd_q     <= wd_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign dir_o   = dir_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// motor_pwm_driver
// Multi-channel PWM driver for H-bridges, fed by PID command strobes. Holds
// the shared period counter, the period tick and the command write decode;
// all per-channel behaviour lives in pwm_channel.
//   clk, rst       : clock, synchronous active-high reset
//   u_valid_i      : command strobe (always accepted)
//   u_chn_i        : command channel (out-of-range channels are dropped)
//   u_data_i       : signed command effort
//   pwm_o          : per-channel PWM
//   dir_o          : per-channel direction, 1 = reverse
//   fault_o        : per-channel command timeout
//   period_tick_o  : one-cycle pulse marking the start of each output period
// ---------------------------------------------------------------------------
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int DATA_WIDTH      = MOTOR_DATA_WIDTH,
    parameter int NUM_CHN         = MOTOR_NUM_CHN,
    parameter int PWM_PERIOD      = 1000,
    parameter int TIMEOUT_PERIODS = 100,
    localparam int CHN_WIDTH      = chn_width(NUM_CHN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         u_valid_i,
    input  logic [CHN_WIDTH-1:0]         u_chn_i,
    input  logic signed [DATA_WIDTH-1:0] u_data_i,
    output logic [NUM_CHN-1:0]           pwm_o,
    output logic [NUM_CHN-1:0]           dir_o,
    output logic [NUM_CHN-1:0]           fault_o,
    output logic                         period_tick_o
);

    localparam int CNT_W = $clog2(PWM_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             load;
    logic             start;

    always_comb begin
        load   = (cnt_q == CNT_W'(PWM_PERIOD - 1));
        start  = (cnt_q == '0);
        cnt_d  = load ? '0 : cnt_q + 1'b1;
        // Registered like pwm_o, so the tick lines up with the first PWM
        // sample of each period and first appears right after reset release.
        tick_d = start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign period_tick_o = tick_q;

    for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
        logic wr;
        assign wr = u_valid_i && (u_chn_i == CHN_WIDTH'(i));

        pwm_channel #(
            .DATA_WIDTH      (DATA_WIDTH),
            .PWM_PERIOD      (PWM_PERIOD),
            .TIMEOUT_PERIODS (TIMEOUT_PERIODS)
        ) u_chn (
            .clk     (clk),
            .rst     (rst),
            .cnt_i   (cnt_q),
            .load_i  (load),
            .start_i (start),
            .wr_i    (wr),
            .data_i  (u_data_i),
            .pwm_o   (pwm_o[i]),
            .dir_o   (dir_o[i]),
            .fault_o (fault_o[i])
        );
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
module tb_motor_pwm_driver;

    localparam int P  = 100;
    localparam int T  = 4;
    localparam int NC = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               u_valid_i = 1'b0;
    logic [1:0]         u_chn_i = '0;
    logic signed [15:0] u_data_i = '0;
    logic [NC-1:0]      pwm_o;
    logic [NC-1:0]      dir_o;
    logic [NC-1:0]      fault_o;
    logic               period_tick_o;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .DATA_WIDTH      (16),
        .NUM_CHN         (NC),
        .PWM_PERIOD      (P),
        .TIMEOUT_PERIODS (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .u_valid_i     (u_valid_i),
        .u_chn_i       (u_chn_i),
        .u_data_i      (u_data_i),
        .pwm_o         (pwm_o),
        .dir_o         (dir_o),
        .fault_o       (fault_o),
        .period_tick_o (period_tick_o)
    );

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_print = 0;

    // Reference model state: the values the outputs should hold after the
    // most recent clock edge.
    int         m_cnt = 0;
    int         m_shadow[NC];
    int         m_act[NC];
    int         m_since[NC];
    bit         m_blank[NC];
    logic [3:0] m_pwm   = '0;
    logic [3:0] m_dir   = '0;
    logic [3:0] m_fault = '0;
    logic       m_tick  = 1'b0;

    typedef struct {
        int ch;
        int data;
        int exp_hi;
        bit exp_dir;
    } vec_t;
    vec_t tbl[10];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
            end
        end
    endfunction

    // Applies the specification rules to one clock edge with the given inputs.
    task automatic model_update(input logic r, input logic v, input int ch, input int d);
        int  val, mag, duty;
        bit  wr, tmo, neg, start, load;
        if (r) begin
            m_cnt = 0;
            for (int i = 0; i < NC; i++) begin
                m_shadow[i] = 0; m_act[i] = 0; m_since[i] = 0; m_blank[i] = 0;
            end
            m_pwm = '0; m_dir = '0; m_fault = '0; m_tick = 1'b0;
            return;
        end
        start  = (m_cnt == 0);
        load   = (m_cnt == P - 1);
        m_tick = start;
        for (int i = 0; i < NC; i++) begin
            wr  = v && (ch == i);
            tmo = start && !wr && (m_since[i] == T - 1);
            m_pwm[i] = !m_blank[i] && !tmo && (m_cnt < m_act[i]);
            val = wr ? d : m_shadow[i];
            if (load) begin
                mag  = (val < 0) ? -val : val;
                duty = (mag > P) ? P : mag;
                neg  = (val < 0);
                if (m_blank[i]) begin
                    m_blank[i] = 0;
                    if (duty != 0) m_dir[i] = neg;
                end else if (duty != 0 && neg != m_dir[i]) begin
                    m_blank[i] = 1;
                end
                m_act[i] = duty;
            end
            if (wr) begin
                m_shadow[i] = val; m_since[i] = 0; m_fault[i] = 1'b0;
            end else if (tmo) begin
                m_shadow[i] = 0; m_act[i] = 0; m_blank[i] = 0;
                m_fault[i] = 1'b1; m_since[i] = T;
            end else if (start && m_since[i] < T) begin
                m_since[i]++;
            end
        end
        m_cnt = (m_cnt + 1) % P;
    endtask

    // Drive one cycle's inputs, advance the model, and compare at the falling edge.
    task automatic step(input logic r, input logic v, input int ch, input int d);
        rst       = r;
        u_valid_i = v;
        u_chn_i   = 2'(ch);
        u_data_i  = 16'(d);
        model_update(r, v, ch, d);
        @(negedge clk);
        chk("scoreboard{pwm,dir,fault,tick}", {19'd0, pwm_o, dir_o, fault_o, period_tick_o},
            {19'd0, m_pwm, m_dir, m_fault, m_tick});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        while (m_cnt != target && k < 2 * P) begin
            idle();
            k++;
        end
        if (m_cnt != target) chk("wait_cnt_bound", m_cnt, target);
    endtask

    task automatic write_at(input int ch, input int d, input int c);
        wait_cnt(c);
        step(1'b0, 1'b1, ch, d);
    endtask

    // Expects m_cnt==0: counts high clocks across one full output period,
    // optionally injecting a write at cnt==wcnt. dir_pre is sampled before
    // the period's closing edge.
    task automatic measure(input int ch, input int wcnt, input int wdata,
                           output int hi, output logic dir_pre);
        hi = 0;
        dir_pre = dir_o[ch];
        for (int k = 0; k < P; k++) begin
            if (k == P - 1) dir_pre = dir_o[ch];
            if (m_cnt == wcnt) step(1'b0, 1'b1, ch, wdata);
            else               idle();
            hi += int'(pwm_o[ch]);
        end
    endtask

    initial begin
        int   hi, ticks, r, v, ch, d;
        logic dp;

        tbl[0] = '{0,  40,     40,  1'b0};
        tbl[1] = '{0, -40,     40,  1'b1};
        tbl[2] = '{0,   0,      0,  1'b1};
        tbl[3] = '{0,  100,   100,  1'b0};
        tbl[4] = '{1, -32768, 100,  1'b1};
        tbl[5] = '{1,  250,   100,  1'b0};
        tbl[6] = '{2,    1,     1,  1'b0};
        tbl[7] = '{3,  -99,    99,  1'b1};
        tbl[8] = '{3,  32767, 100,  1'b0};
        tbl[9] = '{2,   -1,     1,  1'b1};

        // Reset state and first tick after release.
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        chk("reset_pwm",   pwm_o, 0);
        chk("reset_dir",   dir_o, 0);
        chk("reset_fault", fault_o, 0);
        chk("reset_tick",  period_tick_o, 0);
        idle();
        chk("tick_first_release", period_tick_o, 1);
        idle();
        chk("tick_single_cycle", period_tick_o, 0);

        // Duty / direction / saturation vectors.
        foreach (tbl[i]) begin
            write_at(tbl[i].ch, tbl[i].data, 50);
            wait_cnt(P - 1); idle();
            wait_cnt(P - 1); idle();
            measure(tbl[i].ch, -1, 0, hi, dp);
            chk($sformatf("vec%0d_high", i), hi, tbl[i].exp_hi);
            chk($sformatf("vec%0d_dir", i), dir_o[tbl[i].ch], tbl[i].exp_dir);
            chk($sformatf("vec%0d_fault", i), fault_o[tbl[i].ch], 0);
        end

        // Reversal with one dead period.
        write_at(2, 30, 50);
        wait_cnt(P - 1); idle();
        wait_cnt(P - 1); idle();
        measure(2, 50, -30, hi, dp);
        chk("rev_periodA_high", hi, 30);
        chk("rev_periodA_dir", dir_o[2], 0);
        measure(2, -1, 0, hi, dp);
        chk("rev_dead_high", hi, 0);
        chk("rev_dead_dir_held", dp, 0);
        chk("rev_dir_at_load", dir_o[2], 1);
        measure(2, -1, 0, hi, dp);
        chk("rev_periodC_high", hi, 30);

        // Reset in the middle of a dead period.
        write_at(2, 30, 50);
        wait_cnt(40);
        chk("dead_before_reset", pwm_o[2], 0);
        step(1'b1, 1'b0, 0, 0);
        chk("midreset_pwm",   pwm_o, 0);
        chk("midreset_dir",   dir_o, 0);
        chk("midreset_fault", fault_o, 0);
        chk("midreset_tick",  period_tick_o, 0);
        idle();
        chk("midreset_tick_release", period_tick_o, 1);

        // Boundary write in the load cycle, then a mid-period write.
        write_at(3, 70, P - 1);
        measure(3, -1, 0, hi, dp);
        chk("bound_load_cycle_high", hi, 70);
        measure(3, 50, 10, hi, dp);
        chk("bound_midperiod_unchanged", hi, 70);
        measure(3, -1, 0, hi, dp);
        chk("bound_next_period", hi, 10);

        // Watchdog timeout and recovery.
        write_at(0, 50, 10);
        ticks = 0;
        for (int k = 0; k < 6 * P && !fault_o[0]; k++) begin
            idle();
            if (period_tick_o) ticks++;
        end
        chk("timeout_fault_set", fault_o[0], 1);
        chk("timeout_tick_count", ticks, T);
        chk("timeout_pwm_low", pwm_o[0], 0);
        idle();
        chk("timeout_pwm_low_next", pwm_o[0], 0);
        step(1'b0, 1'b1, 0, 20);
        chk("fault_cleared", fault_o[0], 0);
        wait_cnt(P - 1); idle();
        measure(0, -1, 0, hi, dp);
        chk("after_fault_high", hi, 20);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            r  = ($urandom_range(0, 599) == 0) ? 1 : 0;
            v  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ch = int'($urandom_range(0, NC - 1));
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = -32768;
                2:       d = 32767;
                3:       d = int'($urandom_range(0, 300)) - 150;
                default: d = int'($signed(16'($urandom)));
            endcase
            step(r[0], v[0], ch, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
